// File: rtl/hazard_tracker.sv
// hazard_tracker
// Tracks the destination register of every instruction issued past ID
// through DEPTH downstream stages (stage 0 = EXE, the youngest). From that
// record it raises the read-after-write interlock for ID, reports the
// youngest producing stage of each source for the forwarding muxes, and
// squashes the youngest FLUSH_DEPTH stages when a branch is taken in EXE.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   id_valid_i          ID holds a real instruction
//   rs1_en_i/rs1_addr_i source 1 read enable and address
//   rs2_en_i/rs2_addr_i source 2 read enable and address
//   rd_en_i/rd_addr_i   ID instruction writes rd_addr_i
//   flush_i             branch taken in EXE
//   stall_o             hold IF/ID and insert a bubble
//   issue_o             the ID instruction advances this cycle
//   fwdN_hit_o          source N matches a tracked stage
//   fwdN_stage_o        youngest matching stage for source N (0 if no hit)
//   inflight_o          number of valid tracked entries
//   retire_valid_o      valid flag of the oldest stage
//   retire_addr_o       destination address held in the oldest stage
module hazard_tracker #(
  parameter int REG_ADDR_LEN  = 5,
  parameter int DEPTH         = 3,
  parameter int WRITE_THROUGH = 1,
  parameter int ZERO_REG      = 1,
  parameter int FLUSH_DEPTH   = 1,
  localparam int StageW       = $clog2(DEPTH),
  localparam int CountW       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid_i,
  input  logic                    rs1_en_i,
  input  logic [REG_ADDR_LEN-1:0] rs1_addr_i,
  input  logic                    rs2_en_i,
  input  logic [REG_ADDR_LEN-1:0] rs2_addr_i,
  input  logic                    rd_en_i,
  input  logic [REG_ADDR_LEN-1:0] rd_addr_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic                    issue_o,
  output logic                    fwd1_hit_o,
  output logic [StageW-1:0]       fwd1_stage_o,
  output logic                    fwd2_hit_o,
  output logic [StageW-1:0]       fwd2_stage_o,
  output logic [CountW-1:0]       inflight_o,
  output logic                    retire_valid_o,
  output logic [REG_ADDR_LEN-1:0] retire_addr_o
);

  // With a write-through register file the oldest stage has already written
  // by the time ID reads, so it is excluded from hazard detection.
  localparam int LastHazardStage = (WRITE_THROUGH != 0) ? DEPTH - 2 : DEPTH - 1;
  localparam bit ZeroHardwired   = (ZERO_REG != 0);

  logic [DEPTH-1:0]                   stageValid_q, stageValid_d;
  logic [DEPTH-1:0][REG_ADDR_LEN-1:0] stageDest_q, stageDest_d;
  logic [DEPTH-1:0]                   hit1Vec, hit2Vec;
  logic                               src1Live, src2Live;
  logic                               match1, match2;
  logic                               stallInt, issueInt;

  // A source that is not read, or that reads the hardwired zero register,
  // can never depend on an in-flight write.
  assign src1Live = rs1_en_i && !(ZeroHardwired && (rs1_addr_i == '0));
  assign src2Live = rs2_en_i && !(ZeroHardwired && (rs2_addr_i == '0));

  // Per-stage compare of both sources against every hazard-relevant stage.
  always_comb begin
    hit1Vec = '0;
    hit2Vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i <= LastHazardStage) begin
        hit1Vec[i] = src1Live && stageValid_q[i] && (stageDest_q[i] == rs1_addr_i);
        hit2Vec[i] = src2Live && stageValid_q[i] && (stageDest_q[i] == rs2_addr_i);
      end
    end
  end

  // Priority pick of the youngest (lowest index) matching stage; scanning from
  // the oldest down lets the last assignment win.
  always_comb begin
    match1       = 1'b0;
    match2       = 1'b0;
    fwd1_stage_o = '0;
    fwd2_stage_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit1Vec[i]) begin
        match1       = 1'b1;
        fwd1_stage_o = StageW'(i);
      end
      if (hit2Vec[i]) begin
        match2       = 1'b1;
        fwd2_stage_o = StageW'(i);
      end
    end
  end

  // Flush overrides the interlock: the ID instruction is being discarded, so
  // it neither stalls nor issues. Reset forces both low while asserted.
  assign stallInt = !rst && id_valid_i && !flush_i && (match1 || match2);
  assign issueInt = !rst && id_valid_i && !flush_i && !stallInt;

  assign stall_o    = stallInt;
  assign issue_o    = issueInt;
  assign fwd1_hit_o = match1;
  assign fwd2_hit_o = match2;

  // Next state of the shift pipeline. On flush the entries leaving the
  // youngest FLUSH_DEPTH stages arrive invalid in their successors.
  always_comb begin
    stageValid_d    = '0;
    stageDest_d     = '0;
    stageValid_d[0] = issueInt && rd_en_i && !(ZeroHardwired && (rd_addr_i == '0));
    stageDest_d[0]  = rd_addr_i;
    for (int i = 1; i < DEPTH; i++) begin
      stageValid_d[i] = stageValid_q[i-1] && !(flush_i && ((i - 1) < FLUSH_DEPTH));
      stageDest_d[i]  = stageDest_q[i-1];
    end
  end

  // Tracking register; shifts every cycle, reset drops every entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stageValid_q <= '0;
      stageDest_q  <= '0;
    end else begin
      stageValid_q <= stageValid_d;
      stageDest_q  <= stageDest_d;
    end
  end

  // Occupancy count straight from the registered valid bits.
  always_comb begin
    inflight_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      inflight_o = inflight_o + CountW'(stageValid_q[i]);
    end
  end

  assign retire_valid_o = stageValid_q[DEPTH-1];
  assign retire_addr_o  = stageDest_q[DEPTH-1];

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker
// Drives two hazard_tracker instances (write-through and not) from the same
// inputs. Directed table vectors hold hand-derived expectations for the
// write-through instance; every cycle both instances are also compared with
// a reference model that keeps a per-cycle log of issued writes and derives
// each entry's stage from its age.
module tb_hazard_tracker;

  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int FD    = 1;
  localparam int LOGN  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          idValid = 1'b0, rs1En = 1'b0, rs2En = 1'b0, rdEn = 1'b0, flush = 1'b0;
  logic [AW-1:0] rs1Addr = '0, rs2Addr = '0, rdAddr = '0;

  logic          stallW, issueW, f1HitW, f2HitW, retVW;
  logic [1:0]    f1StageW, f2StageW, inflightW;
  logic [AW-1:0] retAW;
  logic          stallN, issueN, f1HitN, f2HitN, retVN;
  logic [1:0]    f1StageN, f2StageN, inflightN;
  logic [AW-1:0] retAN;

  int nVec = 0;
  int nErr = 0;
  int cyc  = 0;

  // Reference model state: one record per cycle of a register write issued in
  // that cycle; entries older than floorCyc were wiped by reset.
  bit     recValid [2][LOGN];
  int     recAddr  [2][LOGN];
  int     floorCyc = 0;
  logic   mSt[2], mIss[2], mH1[2], mH2[2], mRv[2];
  int     mS1[2], mS2[2], mInf[2], mRa[2];

  typedef struct {
    logic r, idv, r1e; int r1a; logic r2e; int r2a; logic rde; int rda; logic fl;
    logic eSt, eIss, eH1; int eS1; logic eH2; int eS2; int eInf; logic eRv; int eRa;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_tracker #(.REG_ADDR_LEN(AW), .DEPTH(DEPTH), .WRITE_THROUGH(1), .ZERO_REG(1),
                   .FLUSH_DEPTH(FD)) dutWt (
    .clk(clk), .rst(rst), .id_valid_i(idValid),
    .rs1_en_i(rs1En), .rs1_addr_i(rs1Addr), .rs2_en_i(rs2En), .rs2_addr_i(rs2Addr),
    .rd_en_i(rdEn), .rd_addr_i(rdAddr), .flush_i(flush),
    .stall_o(stallW), .issue_o(issueW), .fwd1_hit_o(f1HitW), .fwd1_stage_o(f1StageW),
    .fwd2_hit_o(f2HitW), .fwd2_stage_o(f2StageW), .inflight_o(inflightW),
    .retire_valid_o(retVW), .retire_addr_o(retAW));

  hazard_tracker #(.REG_ADDR_LEN(AW), .DEPTH(DEPTH), .WRITE_THROUGH(0), .ZERO_REG(1),
                   .FLUSH_DEPTH(FD)) dutNwt (
    .clk(clk), .rst(rst), .id_valid_i(idValid),
    .rs1_en_i(rs1En), .rs1_addr_i(rs1Addr), .rs2_en_i(rs2En), .rs2_addr_i(rs2Addr),
    .rd_en_i(rdEn), .rd_addr_i(rdAddr), .flush_i(flush),
    .stall_o(stallN), .issue_o(issueN), .fwd1_hit_o(f1HitN), .fwd1_stage_o(f1StageN),
    .fwd2_hit_o(f2HitN), .fwd2_stage_o(f2StageN), .inflight_o(inflightN),
    .retire_valid_o(retVN), .retire_addr_o(retAN));

  function automatic vec_t mkVec(input logic r, idv, r1e, input int r1a, input logic r2e,
                                 input int r2a, input logic rde, input int rda, input logic fl,
                                 input logic eSt, eIss, eH1, input int eS1, input logic eH2,
                                 input int eS2, input int eInf, input logic eRv, input int eRa);
    vec_t v;
    v.r = r; v.idv = idv; v.r1e = r1e; v.r1a = r1a; v.r2e = r2e; v.r2a = r2a;
    v.rde = rde; v.rda = rda; v.fl = fl;
    v.eSt = eSt; v.eIss = eIss; v.eH1 = eH1; v.eS1 = eS1; v.eH2 = eH2; v.eS2 = eS2;
    v.eInf = eInf; v.eRv = eRv; v.eRa = eRa;
    return v;
  endfunction

  // Model evaluation for instance m (0 = write-through, 1 = not): an entry
  // written in cycle t sits in stage cyc-1-t; it may hazard only up to the
  // last stage that has not yet written the register file.
  function automatic void modelEval(input int m);
    int maxAge;
    maxAge = (m == 0) ? DEPTH - 2 : DEPTH - 1;
    mSt[m] = 0; mIss[m] = 0; mH1[m] = 0; mH2[m] = 0; mRv[m] = 0;
    mS1[m] = 0; mS2[m] = 0; mInf[m] = 0; mRa[m] = 0;
    if (rst) return;
    for (int k = 0; k < DEPTH; k++) begin
      int t;
      t = cyc - 1 - k;
      if (t < floorCyc || t < 0) continue;
      if (!recValid[m][t]) continue;
      mInf[m]++;
      if (k == DEPTH - 1) begin
        mRv[m] = 1;
        mRa[m] = recAddr[m][t];
      end
      if (k <= maxAge) begin
        if (!mH1[m] && rs1En && rs1Addr != 0 && recAddr[m][t] == int'(rs1Addr)) begin
          mH1[m] = 1; mS1[m] = k;
        end
        if (!mH2[m] && rs2En && rs2Addr != 0 && recAddr[m][t] == int'(rs2Addr)) begin
          mH2[m] = 1; mS2[m] = k;
        end
      end
    end
    mSt[m]  = idValid && !flush && (mH1[m] || mH2[m]);
    mIss[m] = idValid && !flush && !mSt[m];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Compare one instance with the model; retire_addr is meaningful only when
  // its valid flag is set or while reset forces it to zero.
  task automatic checkInstance(input int m, input string tag, input logic st, iss, h1,
                               input logic [1:0] s1, input logic h2, input logic [1:0] s2,
                               input logic [1:0] inf, input logic rv, input logic [AW-1:0] ra);
    modelEval(m);
    checkOutput({tag, ".stall"}, 32'(st), 32'(mSt[m]));
    checkOutput({tag, ".issue"}, 32'(iss), 32'(mIss[m]));
    checkOutput({tag, ".fwd1_hit"}, 32'(h1), 32'(mH1[m]));
    checkOutput({tag, ".fwd1_stage"}, 32'(s1), 32'(mS1[m]));
    checkOutput({tag, ".fwd2_hit"}, 32'(h2), 32'(mH2[m]));
    checkOutput({tag, ".fwd2_stage"}, 32'(s2), 32'(mS2[m]));
    checkOutput({tag, ".inflight"}, 32'(inf), 32'(mInf[m]));
    checkOutput({tag, ".retire_valid"}, 32'(rv), 32'(mRv[m]));
    if (mRv[m] || rst) checkOutput({tag, ".retire_addr"}, 32'(ra), 32'(mRa[m]));
  endtask

  // Drive one cycle's inputs, wait for the settle point, check both instances.
  task automatic applyStimulus(input vec_t v);
    rst = v.r; idValid = v.idv;
    rs1En = v.r1e; rs1Addr = AW'(v.r1a);
    rs2En = v.r2e; rs2Addr = AW'(v.r2a);
    rdEn = v.rde; rdAddr = AW'(v.rda); flush = v.fl;
    @(negedge clk);
    checkInstance(0, "wt",  stallW, issueW, f1HitW, f1StageW, f2HitW, f2StageW, inflightW, retVW, retAW);
    checkInstance(1, "nwt", stallN, issueN, f1HitN, f1StageN, f2HitN, f2StageN, inflightN, retVN, retAN);
  endtask

  // Record this cycle's effect in the model, then move past the clock edge.
  task automatic advance();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        floorCyc = cyc + 1;
      end else begin
        recValid[m][cyc] = mIss[m] && rdEn && (rdAddr != 0);
        recAddr[m][cyc]  = int'(rdAddr);
        if (flush) begin
          for (int k = 0; k < FD; k++) begin
            if (cyc - 1 - k >= 0) recValid[m][cyc-1-k] = 0;
          end
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Main sequence: directed table, write-back-only hazard window, random run.
  initial begin
    vec_t v;
    //                 r idv r1e r1a r2e r2a rde rda fl | st is h1 s1 h2 s2 inf rv ra
    tbl.push_back(mkVec(1, 1, 1, 9, 0, 0, 1, 9, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 5, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 1, 5, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mkVec(0, 1, 1, 5, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mkVec(0, 1, 1, 5, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 1, 5));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 3, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 4, 0,   0, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mkVec(0, 1, 1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mkVec(0, 1, 1, 2, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 2, 1, 3));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 1, 4));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 7, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 1, 7, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mkVec(0, 1, 1, 7, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 9, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 9, 0,   0, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 9, 0,   0, 1, 0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mkVec(1, 1, 1, 9, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 1, 9, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 6, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 1, 6, 1, 8, 0,   1, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 1, 6, 1, 8, 0,   1, 0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mkVec(0, 1, 0, 0, 1, 6, 1, 8, 0,   0, 1, 0, 0, 0, 0, 1, 1, 6));
    tbl.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0));

    #1;
    foreach (tbl[n]) begin
      applyStimulus(tbl[n]);
      checkOutput("tbl.stall", 32'(stallW), 32'(tbl[n].eSt));
      checkOutput("tbl.issue", 32'(issueW), 32'(tbl[n].eIss));
      checkOutput("tbl.fwd1_hit", 32'(f1HitW), 32'(tbl[n].eH1));
      checkOutput("tbl.fwd1_stage", 32'(f1StageW), 32'(tbl[n].eS1));
      checkOutput("tbl.fwd2_hit", 32'(f2HitW), 32'(tbl[n].eH2));
      checkOutput("tbl.fwd2_stage", 32'(f2StageW), 32'(tbl[n].eS2));
      checkOutput("tbl.inflight", 32'(inflightW), 32'(tbl[n].eInf));
      checkOutput("tbl.retire_valid", 32'(retVW), 32'(tbl[n].eRv));
      if (tbl[n].eRv || tbl[n].r) checkOutput("tbl.retire_addr", 32'(retAW), 32'(tbl[n].eRa));
      advance();
    end

    // Without write-through the reader must wait one cycle longer: writer of
    // r5 in cycle 0, reader stalls in cycles 1..3 and issues in cycle 4.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
      advance();
    end
    applyStimulus(mkVec(0, 1, 0, 0, 0, 0, 1, 5, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("nwt_seq.issue_writer", 32'(issueN), 32'd1);
    advance();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(mkVec(0, 1, 1, 5, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
      checkOutput("nwt_seq.stall", 32'(stallN), (k < 4) ? 32'd1 : 32'd0);
      checkOutput("nwt_seq.issue", 32'(issueN), (k == 4) ? 32'd1 : 32'd0);
      advance();
    end

    // Randomised traffic over a small register range so hazards are common.
    for (int n = 0; n < 1500; n++) begin
      v = mkVec($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7) == 0,
                0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(v);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Parametrised in-flight write tracker and stall generator for the pipelined processor. It sits beside the ID stage and records the destination register of every instruction issued past ID, through DEPTH downstream stages. It stalls ID on read-after-write hazards, reports the youngest matching stage per source for forwarding, and squashes entries on branch flush. It adds the interlock that the current five-stage pipeline lacks.

## Interface
Parameters:
- REG_ADDR_LEN, 5: register address width.
- DEPTH, 3: tracked stages after ID (EXE, MEM, WB); legal range 2..8.
- WRITE_THROUGH, 1: 1 = register file writes before reads in the same cycle, so the oldest stage never causes a hazard.
- ZERO_REG, 1: 1 = address 0 never hazards and is never recorded.
- FLUSH_DEPTH, 1: number of youngest tracked stages squashed on flush; legal range 0..DEPTH-1.

Ports:
- clk, in, 1: clock; single clock domain.
- rst, in, 1: reset, asynchronous, active-high.
- id_valid, in, 1: ID holds a real instruction.
- rs1_en, in, 1: source 1 is read.
- rs1_addr, in, REG_ADDR_LEN: source 1 address.
- rs2_en, in, 1: source 2 is read.
- rs2_addr, in, REG_ADDR_LEN: source 2 address.
- rd_en, in, 1: the ID instruction writes a register.
- rd_addr, in, REG_ADDR_LEN: destination address.
- flush, in, 1: branch taken in EXE.
- stall, out, 1: hold IF and ID; insert a bubble.
- issue, out, 1: the ID instruction advances this cycle.
- fwd1_hit, out, 1: source 1 matches a tracked stage.
- fwd1_stage, out, $clog2(DEPTH): youngest matching stage index for source 1.
- fwd2_hit, out, 1: source 2 matches a tracked stage.
- fwd2_stage, out, $clog2(DEPTH): youngest matching stage index for source 2.
- inflight, out, $clog2(DEPTH+1): count of valid tracked entries.
- retire_valid, out, 1: valid flag of stage DEPTH-1.
- retire_addr, out, REG_ADDR_LEN: destination address in stage DEPTH-1.

## Operation
- State: one shift pipeline of DEPTH entries, each {valid, dest}. Stage 0 is the youngest (EXE). There is no other FSM.
- Match for a source:
  - The source is enabled.
  - A stage i is valid with dest equal to the source address.
  - i < DEPTH-1 when WRITE_THROUGH=1; any i otherwise.
  - The address is nonzero when ZERO_REG=1.
- fwdN_hit and fwdN_stage: combinational. fwdN_stage is the lowest matching i. It is 0 when there is no hit. Computed regardless of id_valid.
- stall = id_valid & !flush & (match1 | match2).
- issue = id_valid & !flush & !stall.
- Shift on every clock, with no enable:
  - stage[i+1] <= stage[i].
  - stage[0] <= {issue & rd_en & !(ZERO_REG & rd_addr==0), rd_addr}.
- Flush: stages 0..FLUSH_DEPTH-1 have valid cleared as they shift. Their successors in stages 1..FLUSH_DEPTH load invalid. Stage 0 loads invalid because issue=0. Dest bits are don't-care when invalid.
- flush wins over stall; stall is 0 whenever flush=1.
- inflight: popcount of the valid bits, taken from registers.
- Reset (asynchronous): all valid=0, all dest=0. While rst=1, stall=0, issue=0, fwd*=0, inflight=0, retire_valid=0, retire_addr=0. Reset mid-operation drops all tracked entries immediately. The first cycle after deassertion issues with no hazards.

## Timing
- stall, issue and fwd* are combinational from the inputs and the registered state, with zero-cycle latency. They are valid before the clk rising edge.
- An instruction issued in cycle t:
  - occupies stage k in cycle t+1+k;
  - raises retire_valid in cycle t+DEPTH;
  - is gone in cycle t+DEPTH+1.
- Earliest issue of a dependent reader: cycle t+DEPTH when WRITE_THROUGH=1; cycle t+DEPTH+1 when WRITE_THROUGH=0.
- A stall keeps requiring the same ID inputs. The block does not latch them; upstream holds them.
- Issue in consecutive cycles is fully pipelined, with throughput of one per cycle when no hazard exists.

## Test plan
All scenarios use defaults (DEPTH=3, WRITE_THROUGH=1, FLUSH_DEPTH=1) unless stated.
- Issue rd=r5 in cycle 0; reader rs1=r5 presented in cycles 1..3 -> stall=1 in cycles 1 and 2, issue=1 in cycle 3. fwd1_stage=0 in cycle 1 and 1 in cycle 2. retire_valid=1 and retire_addr=5 in cycle 3.
- Same as the first scenario with WRITE_THROUGH=0 -> stall in cycles 1..3, issue in cycle 4.
- Writers r3 and r4 issued back to back, then readers r1 and r2 -> no stall, issue=1 every cycle, inflight goes 1, 2, 2, 1, 0.
- rd=r0 issued, then reader rs2=r0 -> no stall, inflight=0 (ZERO_REG=1).
- Issue rd=r7 in cycle 0; in cycle 1, flush=1 while a reader of r7 is present:
  - cycle 1: stall=0, issue=0;
  - cycle 2: stage 1 invalid, inflight=0;
  - a reader of r7 presented in cycle 2 issues with no stall.
- Fill three r9 writes, then assert rst for one cycle mid-stream -> all outputs are 0 immediately; inflight=0 after release; a reader of r9 issues in the first cycle after release.
